pwm_audio_out: RTL and testbench
================================

// Module: pwm_audio_out
// PURPOSE
//  Downstream audio output stage: consumes the 29-bit signed filter-sum sample
//  (latched on the sample flag) and drives a 1-bit PWM audio pin. Converts two's
//  complement to offset-binary duty with saturation and double-buffers the duty
//  (updates only at PWM period boundaries). Soft-start/soft-stop ramps to/from
//  midscale suppress pops.
// PARAMETERS
//  DATA_W     29  input sample width, two's complement
//  SHIFT      16  LSBs dropped (arithmetic shift right) before saturation
//  PWM_BITS   10  duty/counter width; PWM period = 2^PWM_BITS clk cycles
//  RAMP_STEP  1   duty change per period during RAMP_UP/RAMP_DOWN
// PORTS
//  clk           in   1         system clock, all logic on rising edge
//  rst           in   1         asynchronous reset, active-high
//  en            in   1         1 = play (ramp up then RUN); 0 = ramp down to IDLE
//  sample_in     in   DATA_W    signed sample from filter summer
//  sample_valid  in   1         1-cycle qualifier for sample_in
//  sample_req    out  1         1-cycle pulse: period ends, next sample wanted
//  pwm_out       out  1         PWM audio bit
//  clip          out  1         1-cycle pulse: captured sample was saturated
//  state_o       out  2         00 IDLE, 01 RAMP_UP, 10 RUN, 11 RAMP_DOWN
// BEHAVIOUR
//  - Reset (async): cnt=0, duty=0, pending=midscale, pend_v=0, state IDLE; all outputs 0.
//  - Convert: v = sample_in >>> SHIFT; sat to [-2^(N-1), 2^(N-1)-1] (N=PWM_BITS);
//    pend = v + 2^(N-1). clip pulses the cycle after a sat-clamped capture.
//  - Capture: sample_valid -> pend/pend_v written next edge, any state; several
//    valids in one period: last wins. sample_valid while pend consumed at boundary:
//    new sample wins, pend_v stays 1.
//  - Counter: free-runs 0..2^N-1, wraps, in all states except IDLE (held 0).
//    Boundary = cycle with cnt==2^N-1.
//  - pwm_out registered: pwm_out <= (cnt < duty) && state!=IDLE; duty 0 -> always 0,
//    duty 2^N-1 -> high 2^N-1 of 2^N cycles. One cycle latency vs cnt.
//  - duty changes only at a boundary (takes effect on cnt=0 period).
//  - IDLE: en=1 -> RAMP_UP next edge, cnt starts at 0, duty=0.
//  - RAMP_UP: each boundary duty moves toward midscale by RAMP_STEP (clamped,
//    down if above); at boundary where duty reaches midscale -> RUN.
//    en=0 -> RAMP_DOWN at next boundary.
//  - RUN: boundary: if pend_v, duty<=pend, pend_v<=0; else duty held (no underrun
//    glitch). sample_req=1 in boundary cycle, RUN only. en=0 -> RAMP_DOWN at
//    next boundary (that boundary's pend still loaded).
//  - RAMP_DOWN: each boundary duty -= RAMP_STEP, clamp 0; boundary where duty
//    is 0 -> IDLE. en=1 -> RAMP_UP at next boundary from current duty.
//  - sample_req never asserted outside RUN; samples accepted but unused there.
//  - Reset mid-operation: immediate return to reset values, pwm_out low at once.
// TESTING
//  1 rst pulse mid-RUN, duty 700 -> pwm_out, sample_req, clip, state_o 0 same cycle; stay IDLE.
//  2 RAMP_STEP=64, en=1 -> duty 64,128..512 on successive boundaries; RUN after 8 periods.
//  3 RUN, sample_in 0 -> next period high 512/1024; 0x01FF0000 -> 1023; 0xFE000000 -> 0.
//  4 sample_in 0x02000000 -> duty 1023, clip pulse 1 cycle; 0x10000000 -> duty 0, clip.
//  5 Two sample_valid in one period (0, then 0x00100000) -> duty 528; none next -> held 528.
//  6 en=0 in RUN, duty 512, RAMP_STEP=64 -> 8 boundaries to 0, IDLE, pwm_out 0, no sample_req.

Source files
------------

// File: rtl/pwm_audio_out.sv
// PWM audio output stage: signed filter sample -> saturated offset-binary duty,
// double-buffered at PWM period boundaries, with soft-start/soft-stop ramps.
module pwm_audio_out #(
    parameter int DATA_W    = 29,
    parameter int SHIFT     = 16,
    parameter int PWM_BITS  = 10,
    parameter int RAMP_STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    output logic                     sample_req,
    output logic                     pwm_out,
    output logic                     clip,
    output logic [1:0]               state_o
);

    localparam logic [1:0] S_IDLE      = 2'b00;
    localparam logic [1:0] S_RAMP_UP   = 2'b01;
    localparam logic [1:0] S_RUN       = 2'b10;
    localparam logic [1:0] S_RAMP_DOWN = 2'b11;

    localparam logic [PWM_BITS-1:0]      MID     = {1'b1, {(PWM_BITS-1){1'b0}}};
    localparam logic [PWM_BITS-1:0]      CNT_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0]      STEP    = PWM_BITS'(RAMP_STEP);
    localparam logic signed [DATA_W-1:0] SAT_HI  = DATA_W'((1 << (PWM_BITS-1)) - 1);
    localparam logic signed [DATA_W-1:0] SAT_LO  = DATA_W'(-(1 << (PWM_BITS-1)));

    // Returns {clipped, duty}; inside the range, adding midscale is just an MSB flip.
    function automatic logic [PWM_BITS:0] saturate(input logic signed [DATA_W-1:0] s);
        logic signed [DATA_W-1:0] v;
        v = s >>> SHIFT;
        if (v > SAT_HI)
            return {1'b1, {PWM_BITS{1'b1}}};
        else if (v < SAT_LO)
            return {1'b1, {PWM_BITS{1'b0}}};
        else
            return {1'b0, ~v[PWM_BITS-1], v[PWM_BITS-2:0]};
    endfunction

    function automatic logic [PWM_BITS-1:0] ramp_up(input logic [PWM_BITS-1:0] d);
        if (d < MID)
            return ((MID - d) <= STEP) ? MID : d + STEP;
        else if (d > MID)
            return ((d - MID) <= STEP) ? MID : d - STEP;
        else
            return MID;
    endfunction

    function automatic logic [PWM_BITS-1:0] ramp_down(input logic [PWM_BITS-1:0] d);
        return (d <= STEP) ? '0 : d - STEP;
    endfunction

    logic [1:0]          state, state_nxt;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty, duty_nxt;
    logic [PWM_BITS-1:0] pend_p0;
    logic                vld_p0;
    logic                load;
    logic                bnd;
    logic [PWM_BITS:0]   conv;

    assign conv       = saturate(sample_in);
    assign bnd        = (state != S_IDLE) && (cnt == CNT_MAX);
    assign sample_req = (state == S_RUN) && (cnt == CNT_MAX);
    assign state_o    = state;

    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                duty_nxt = '0;
                if (en) state_nxt = S_RAMP_UP;
            end
            S_RAMP_UP: if (bnd) begin
                duty_nxt = ramp_up(duty);
                if (!en)                  state_nxt = S_RAMP_DOWN;
                else if (duty_nxt == MID) state_nxt = S_RUN;
            end
            S_RUN: if (bnd) begin
                if (vld_p0) begin
                    duty_nxt = pend_p0;
                    load     = 1'b1;
                end
                if (!en) state_nxt = S_RAMP_DOWN;
            end
            default: if (bnd) begin
                if (en) begin
                    state_nxt = S_RAMP_UP;
                end else begin
                    duty_nxt = ramp_down(duty);
                    if (duty_nxt == '0) state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // Capture stage: a fresh sample always beats the boundary consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_p0 <= MID;
            vld_p0  <= 1'b0;
            clip    <= 1'b0;
        end else if (sample_valid) begin
            pend_p0 <= conv[PWM_BITS-1:0];
            vld_p0  <= 1'b1;
            clip    <= conv[PWM_BITS];
        end else begin
            clip <= 1'b0;
            if (load) vld_p0 <= 1'b0;
        end
    end

    // PWM stage: counter, double-buffered duty and registered comparator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            state   <= state_nxt;
            duty    <= duty_nxt;
            cnt     <= (state == S_IDLE) ? '0 : cnt + 1'b1;
            pwm_out <= (cnt < duty) && (state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Bench for pwm_audio_out: measures high time per PWM period against a duty
// scoreboard, plus state, sample_req and clip pulse counts per period.
module tb_pwm_audio_out;

    localparam int NONE = -2;
    localparam int CONV = -1;
    localparam logic [1:0] IDLE = 2'b00, RUP = 2'b01, RUN = 2'b10, RDN = 2'b11;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic signed [28:0] sample_in = '0;
    logic               sample_valid = 1'b0;
    logic               sample_req, pwm_out, clip;
    logic [1:0]         state_o;

    int checks = 0;
    int errors = 0;
    int expq[$];

    pwm_audio_out #(.DATA_W(29), .SHIFT(16), .PWM_BITS(10), .RAMP_STEP(64)) dut (
        .clk(clk), .rst(rst), .en(en), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_req(sample_req), .pwm_out(pwm_out),
        .clip(clip), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic int conv_model(input logic [28:0] s, output bit c);
        int v;
        v = int'($signed(s)) >>> 16;
        c = 1'b0;
        if (v > 511) begin c = 1'b1; return 1023; end
        if (v < -512) begin c = 1'b1; return 0; end
        return v + 512;
    endfunction

    // One full PWM period, starting at the negedge where cnt==0.
    task automatic run_period(input string tag, input int n, input logic [28:0] s0,
                              input logic [28:0] s1, input logic [1:0] exp_st,
                              input int exp_req, input int nxt);
        int hi = 0, req = 0, clips = 0, exp_clips, e0, e1, ex;
        bit c0, c1;
        logic [1:0] st = '0;
        e0 = conv_model(s0, c0);
        e1 = conv_model(s1, c1);
        exp_clips = ((n >= 1) ? int'(c0) : 0) + ((n >= 2) ? int'(c1) : 0);
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (i == 0) st = state_o;
            hi += int'(pwm_out);
            req += int'(sample_req);
            clips += int'(clip);
            if (i == 100 && n >= 1) begin
                sample_in = s0; sample_valid = 1'b1;
            end else if (i == 200 && n >= 2) begin
                sample_in = s1; sample_valid = 1'b1;
            end else begin
                sample_valid = 1'b0;
            end
        end
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: no expected duty queued, got %0d high cycles", tag, hi);
        end else begin
            ex = expq.pop_front();
            if (hi !== ex) begin
                errors++;
                $display("FAIL %s duty: got %0d high cycles, expected %0d", tag, hi, ex);
            end
        end
        checks++;
        if (st !== exp_st) begin
            errors++;
            $display("FAIL %s state: got %0d expected %0d", tag, st, exp_st);
        end
        checks++;
        if (req !== exp_req) begin
            errors++;
            $display("FAIL %s sample_req: got %0d pulses expected %0d", tag, req, exp_req);
        end
        checks++;
        if (clips !== exp_clips) begin
            errors++;
            $display("FAIL %s clip: got %0d cycles expected %0d", tag, clips, exp_clips);
        end
        if (nxt == CONV) expq.push_back((n >= 2) ? e1 : e0);
        else if (nxt >= 0) expq.push_back(nxt);
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if ({pwm_out, sample_req, clip, state_o} !== 5'b0) begin
            errors++;
            $display("FAIL %s: got pwm=%b req=%b clip=%b state=%0d, expected all 0",
                     tag, pwm_out, sample_req, clip, state_o);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_held");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_outputs_zero("idle_after_reset");
    endtask

    task automatic ramp_to_run(input string tag, input logic [28:0] s, input int nxt);
        for (int k = 0; k <= 8; k++) expq.push_back(64 * k);
        en = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 8; k++) run_period({tag, "_up"}, 0, '0, '0, RUP, 0, NONE);
        run_period({tag, "_first_run"}, (nxt == CONV) ? 1 : 0, s, '0, RUN, 1, nxt);
    endtask

    task automatic test_ramp_up();
        ramp_to_run("ramp", '0, 512);
    endtask

    task automatic test_convert();
        run_period("conv_zero", 1, 29'h0, '0, RUN, 1, CONV);
        run_period("conv_max", 1, 29'h01FF0000, '0, RUN, 1, CONV);
        run_period("conv_min", 1, 29'h1E000000, '0, RUN, 1, CONV);   // 0xFE000000 truncated to 29 bits
    endtask

    task automatic test_clip();
        run_period("clip_pos", 1, 29'h02000000, '0, RUN, 1, CONV);
        run_period("clip_neg", 1, 29'h10000000, '0, RUN, 1, CONV);
    endtask

    task automatic test_back_to_back();
        run_period("b2b_last_wins", 2, 29'h0, 29'h00100000, RUN, 1, CONV);
        run_period("b2b_hold", 0, '0, '0, RUN, 1, 528);
        run_period("b2b_held", 1, 29'h0, '0, RUN, 1, CONV);
    endtask

    task automatic test_ramp_down();
        en = 1'b0;
        for (int k = 0; k < 8; k++)
            run_period("ramp_down", (k == 0) ? 1 : 0, 29'h00BC0000, '0, RDN, 0, 512 - 64 * (k + 1));
        run_period("ramp_down_idle", 0, '0, '0, IDLE, 0, NONE);
    endtask

    task automatic test_reset_mid_run();
        int hi = 0, busy = 0;
        ramp_to_run("rerun", 29'h00BC0000, CONV);
        run_period("run_700", 0, '0, '0, RUN, 1, NONE);
        repeat (300) @(negedge clk);
        checks++;
        if (pwm_out !== 1'b1 || state_o !== RUN) begin
            errors++;
            $display("FAIL pre_reset: got pwm=%b state=%0d, expected pwm=1 state=2", pwm_out, state_o);
        end
        #2 rst = 1'b1;
        en = 1'b0;
        #1 check_outputs_zero("reset_mid_run");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            hi += int'(pwm_out);
            busy += int'(state_o != IDLE) + int'(sample_req);
        end
        checks++;
        if (hi !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL stay_idle: got %0d pwm highs and %0d non-idle cycles, expected 0 and 0", hi, busy);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_convert();
        test_clip();
        test_back_to_back();
        test_ramp_down();
        test_reset_mid_run();
        checks++;
        if (expq.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
